reader_pie_tx: RTL and testbench
================================

// Module: reader_pie_tx
// PURPOSE
//  Interrogator-side Gen2 forward-link transmitter: the counterpart of the tag rx/cmdparser path.
//  Serialises one command frame into PIE-encoded modulation: delimiter, data-0, RTcal,
//  optional TRcal, then payload bits MSB first. Drives the reader ASK modulator; sits under the
//  reader bench top, fed by a command builder. Used as stimulus for tag-level regression.
// PARAMETERS
//  MAX_BITS   64  width of cmd_data; longest payload sendable
//  TARI_CYC   25  clk cycles per data-0 symbol (Tari)
//  D1_CYC     44  clk cycles per data-1 symbol (1.5..2 Tari)
//  PW_CYC     12  clk cycles of low pulse ending every symbol
//  DELIM_CYC  25  clk cycles of low delimiter
//  RTcal is fixed at TARI_CYC+D1_CYC (default 69)
// PORTS
//  clk          in   1         master clock
//  reset        in   1         synchronous, active-low reset
//  start        in   1         request to send frame; sampled only when busy=0
//  preamble     in   1         1: full preamble (with TRcal), 0: frame-sync (no TRcal)
//  trcal_cyc    in   10        TRcal length in clk cycles, latched on start
//  cmd_len      in   8         payload bit count, 0..MAX_BITS, latched on start
//  cmd_data     in   MAX_BITS  payload, MSB-aligned (bit MAX_BITS-1 sent first), latched
//  append_crc   in   1         request CRC-16 append (see CONFIGURATION)
//  modout       out  1         1 = carrier on (CW), 0 = attenuated
//  busy         out  1         high from cycle after accepted start to last PW cycle
//  done         out  1         one-cycle pulse on first CW cycle after the frame
// BEHAVIOUR
//  Reset (reset==0 at posedge): modout=1, busy=0, done=0, FSM->IDLE, counters cleared.
//  Reset mid-frame aborts: next cycle modout=1, no done pulse.
//  FSM: IDLE -> DELIM -> D0 -> RTCAL -> [TRCAL if preamble] -> DATA [-> CRC] -> FIN -> IDLE.
//  Each symbol of length L: modout=1 for L-PW_CYC cycles, then 0 for PW_CYC cycles.
//  DELIM: modout=0 for DELIM_CYC cycles. Latency start->first low modout = 1 cycle.
//  DATA: bit 0 uses L=TARI_CYC, bit 1 uses L=D1_CYC; bit index down-counts from cmd_len-1.
//  cmd_len=0: DATA skipped, frame is preamble/frame-sync only.
//  cmd_len>MAX_BITS: clamped to MAX_BITS.
//  trcal_cyc<=PW_CYC: clamped to PW_CYC+1 (high phase never zero).
//  FIN: single cycle, modout=1, busy=0, done=1; back to IDLE, start accepted the same cycle.
//  start while busy=1: ignored, no queueing. start in FIN cycle: accepted (back-to-back).
//  Inputs other than start are don't-care after latch; changing them mid-frame has no effect.
//  Symbol counter 8 bits wide except TRcal uses the 10-bit latched value; no wrap permitted.
// CONFIGURATION
//  READER_CRC16_EN defined: when append_crc=1 at start, CRC-16 (poly 0x1021, preset 0xFFFF,
//   ones-complemented, MSB first) of the payload is computed serially during DATA and sent as
//   16 further PIE bits in CRC state; busy extends accordingly.
//  READER_CRC16_EN undefined: append_crc ignored, CRC state and logic absent.
// STRUCTURE
//  Shared include reader_defs.vh: FSM state encodings, CRC16 poly/preset localparams,
//   default timing constants (shared with reader-side backscatter decoder).
//  One sub-module: reader_crc16 (serial CRC, bit/bitclk/clear in, 16-bit crc out),
//   instantiated only under READER_CRC16_EN.
// TESTING
//  Reset held 3 cycles mid-DATA -> modout=1 and busy=0 next cycle, no done pulse.
//  start, preamble=0, cmd_len=2, data=2'b00 -> busy 169 cycles (25+25+69+2x25), done at +170.
//  preamble=1, trcal_cyc=138, len=4, data=4'b1010 -> TRcal high 126/low 12; bit lows
//   each 12 cycles; bit highs 32,13,32,13 cycles.
//  cmd_len=0, preamble=1, trcal=100 -> busy 219 cycles, done once, no data symbols.
//  start pulsed mid-frame -> ignored; start in FIN cycle -> new frame, modout low next cycle.
//  READER_CRC16_EN, append_crc=1, data=16'h0000 len 16 -> 16 CRC bits appended equal
//   ~CRC16(0x0000); tag cmdparser reports crc16invalid=0.

Source files
------------

// File: rtl/reader_pie_tx_pkg.sv
// reader_pie_tx_pkg
//   Shared definitions for the reader forward-link transmitter:
//   FSM state encoding, CRC-16 polynomial/preset, default PIE timing
//   constants and a serial CRC-16 step helper.
//   READER_CRC16_EN adds the CRC state to the encoding.
package reader_pie_tx_pkg;

  localparam int unsigned DEF_MAX_BITS  = 64;
  localparam int unsigned DEF_TARI_CYC  = 25;
  localparam int unsigned DEF_D1_CYC    = 44;
  localparam int unsigned DEF_PW_CYC    = 12;
  localparam int unsigned DEF_DELIM_CYC = 25;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELIM = 3'd1,
    ST_D0    = 3'd2,
    ST_RTCAL = 3'd3,
    ST_TRCAL = 3'd4,
    ST_DATA  = 3'd5,
`ifdef READER_CRC16_EN
    ST_CRC   = 3'd6,
`endif
    ST_FIN   = 3'd7
  } state_t;

  // One MSB-first shift of the CRC-16 register.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/reader_crc16.sv
// reader_crc16
//   Serial CRC-16 (poly 0x1021, preset 0xFFFF), MSB first. Only used
//   when READER_CRC16_EN is defined.
// Ports:
//   clk, reset (sync, active-low)
//   clear   - preset the register
//   bitclk  - advance by one bit
//   din     - data bit to absorb
//   crc     - raw (not complemented) CRC register
module reader_crc16
  import reader_pie_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        bitclk,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!reset || clear) crc <= CRC16_PRESET;
    else if (bitclk)     crc <= crc16_step(crc, din);
  end

endmodule

// File: rtl/reader_pie_tx.sv
// reader_pie_tx
//   Gen2 interrogator forward-link PIE transmitter. Sends delimiter,
//   data-0, RTcal, optional TRcal, then cmd_len payload bits MSB first.
//   Optional feature macro: READER_CRC16_EN (appends ~CRC-16 of payload
//   when append_crc=1 at start).
// Ports:
//   clk, reset (sync, active-low)
//   start       - frame request, sampled while busy=0
//   preamble    - 1: include TRcal
//   trcal_cyc   - TRcal length (clamped to >= PW_CYC+1)
//   cmd_len     - payload bits (clamped to MAX_BITS)
//   cmd_data    - payload, bit MAX_BITS-1 sent first
//   append_crc  - CRC-16 append request
//   modout      - 1 = CW, 0 = attenuated
//   busy        - frame in progress
//   done        - one-cycle pulse after the frame
module reader_pie_tx
  import reader_pie_tx_pkg::*;
#(
  parameter int unsigned MAX_BITS  = DEF_MAX_BITS,
  parameter int unsigned TARI_CYC  = DEF_TARI_CYC,
  parameter int unsigned D1_CYC    = DEF_D1_CYC,
  parameter int unsigned PW_CYC    = DEF_PW_CYC,
  parameter int unsigned DELIM_CYC = DEF_DELIM_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                preamble,
  input  logic [9:0]          trcal_cyc,
  input  logic [7:0]          cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  input  logic                append_crc,
  output logic                modout,
  output logic                busy,
  output logic                done
);

  localparam int unsigned RTCAL_CYC = TARI_CYC + D1_CYC;
  localparam logic [9:0]  L_DELIM   = 10'(DELIM_CYC - 1);
  localparam logic [9:0]  L_TARI    = 10'(TARI_CYC - 1);
  localparam logic [9:0]  L_D1      = 10'(D1_CYC - 1);
  localparam logic [9:0]  L_RTCAL   = 10'(RTCAL_CYC - 1);
  localparam logic [9:0]  PW_LIM    = 10'(PW_CYC);
  localparam logic [9:0]  TRCAL_MIN = 10'(PW_CYC + 1);
  localparam logic [7:0]  MAX_LEN   = 8'(MAX_BITS);

  state_t              state, state_n;
  logic [9:0]          cnt, cnt_n;       // cycles left in current symbol
  logic [MAX_BITS-1:0] sh, sh_n;         // payload, next bit at MSB
  logic [7:0]          len_q, len_n;     // payload bits not yet started
  logic                pre_q, pre_n;
  logic [9:0]          trcal_q, trcal_n;
  logic                go_payload;
  logic                crc_clr, crc_clk;

`ifdef READER_CRC16_EN
  logic [4:0]  crc_left, crc_left_n;
  logic [15:0] crc;
  logic        crc_bit;

  // CRC absorbs each payload bit as its symbol is loaded, so the register
  // is final before the CRC symbols begin.
  reader_crc16 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clr),
    .bitclk (crc_clk),
    .din    (sh[MAX_BITS-1]),
    .crc    (crc)
  );
  assign crc_bit = ~crc[4'(crc_left - 5'd1)];
`else
  logic unused_append_crc;
  assign unused_append_crc = append_crc;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sh      <= '0;
      len_q   <= '0;
      pre_q   <= 1'b0;
      trcal_q <= '0;
`ifdef READER_CRC16_EN
      crc_left <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      len_q   <= len_n;
      pre_q   <= pre_n;
      trcal_q <= trcal_n;
`ifdef READER_CRC16_EN
      crc_left <= crc_left_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    len_n      = len_q;
    pre_n      = pre_q;
    trcal_n    = trcal_q;
    go_payload = 1'b0;
    crc_clr    = 1'b0;
    crc_clk    = 1'b0;
`ifdef READER_CRC16_EN
    crc_left_n = crc_left;
`endif
    case (state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          state_n = ST_DELIM;
          cnt_n   = L_DELIM;
          sh_n    = cmd_data;
          len_n   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
          pre_n   = preamble;
          trcal_n = (trcal_cyc <= PW_LIM) ? TRCAL_MIN : trcal_cyc;
          crc_clr = 1'b1;
`ifdef READER_CRC16_EN
          crc_left_n = append_crc ? 5'd16 : 5'd0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DELIM: begin
        if (cnt == '0) begin state_n = ST_D0; cnt_n = L_TARI; end
        else cnt_n = cnt - 10'd1;
      end
      ST_D0: begin
        if (cnt == '0) begin state_n = ST_RTCAL; cnt_n = L_RTCAL; end
        else cnt_n = cnt - 10'd1;
      end
      ST_RTCAL: begin
        if (cnt == '0) begin
          if (pre_q) begin state_n = ST_TRCAL; cnt_n = trcal_q - 10'd1; end
          else go_payload = 1'b1;
        end else cnt_n = cnt - 10'd1;
      end
      default: begin  // TRCAL, DATA, CRC
        if (cnt == '0) go_payload = 1'b1;
        else cnt_n = cnt - 10'd1;
      end
    endcase

    // Shared symbol-boundary selection of the next payload/CRC bit.
    if (go_payload) begin
      if (len_q != '0) begin
        state_n = ST_DATA;
        cnt_n   = sh[MAX_BITS-1] ? L_D1 : L_TARI;
        sh_n    = sh << 1;
        len_n   = len_q - 8'd1;
        crc_clk = 1'b1;
      end
`ifdef READER_CRC16_EN
      else if (crc_left != '0) begin
        state_n    = ST_CRC;
        cnt_n      = crc_bit ? L_D1 : L_TARI;
        crc_left_n = crc_left - 5'd1;
      end
`endif
      else begin
        state_n = ST_FIN;
      end
    end
  end

  always_comb begin
    modout = 1'b1;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_FIN:  done = 1'b1;
      ST_DELIM: begin modout = 1'b0; busy = 1'b1; end
      default: begin modout = (cnt >= PW_LIM); busy = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_reader_pie_tx.sv
module tb_reader_pie_tx;

  logic        clk = 1'b0;
  logic        reset, start, preamble, append_crc;
  logic [9:0]  trcal_cyc;
  logic [7:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        modout, busy, done;

  int total = 0;
  int bad   = 0;
  int lows[$];
  int highs[$];
  int busy_n;

  typedef struct {
    string       name;
    logic        pre;
    logic [9:0]  trcal;
    logic [7:0]  len;
    logic [63:0] data;
    logic        app;
    int          exp_busy;
    int          exp_lowruns;
    int          exp_lowcyc;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  reader_pie_tx #(
    .MAX_BITS  (64),
    .TARI_CYC  (25),
    .D1_CYC    (44),
    .PW_CYC    (12),
    .DELIM_CYC (25)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .preamble   (preamble),
    .trcal_cyc  (trcal_cyc),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .append_crc (append_crc),
    .modout     (modout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic p, input int tr, input int l,
                              input logic [63:0] d, input logic a,
                              input int eb, input int er, input int el);
    vec_t v;
    v.name = n; v.pre = p; v.trcal = 10'(tr); v.len = 8'(l); v.data = d; v.app = a;
    v.exp_busy = eb; v.exp_lowruns = er; v.exp_lowcyc = el;
    return v;
  endfunction

  function automatic logic [15:0] crc_model(input logic [63:0] d, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ d[63-i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return ~c;
  endfunction

  // Request a frame, then scramble the other inputs to show they are latched.
  task automatic launch(input vec_t v);
    @(negedge clk);
    preamble = v.pre; trcal_cyc = v.trcal; cmd_len = v.len;
    cmd_data = v.data; append_crc = v.app; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    preamble = ~v.pre; trcal_cyc = 10'd500; cmd_len = 8'd3;
    cmd_data = ~v.data; append_crc = ~v.app;
  endtask

  // Count busy cycles from the current negedge and record modout run lengths.
  // Optionally pulses start at busy cycle pulse_at. Returns at the FIN negedge.
  task automatic measure(input int pulse_at);
    int   run;
    logic prev;
    busy_n = 0;
    lows.delete();
    highs.delete();
    run  = 0;
    prev = modout;
    while (busy === 1'b1 && busy_n < 4000) begin
      busy_n++;
      if (modout === prev) run++;
      else begin
        if (prev) highs.push_back(run); else lows.push_back(run);
        prev = modout;
        run  = 1;
      end
      start = (busy_n == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (prev) highs.push_back(run); else lows.push_back(run);
    if (busy_n >= 4000) begin
      total++; bad++;
      $display("FAIL busy_timeout: got busy still high after %0d cycles required frame end", busy_n);
    end
  endtask

  function automatic int sum_lows();
    int s = 0;
    foreach (lows[i]) s += lows[i];
    return s;
  endfunction

  initial begin
    int eb, er, el, ones, dcount;
    logic [15:0] cv;

    vecs[0] = mk("fs_len2_00",    1'b0, 0,   2,  64'h0,                  1'b0, 169,  5,  73);
    vecs[1] = mk("pre_len4_1010", 1'b1, 138, 4,  64'hA000_0000_0000_0000, 1'b0, 395,  8,  109);
    vecs[2] = mk("pre_len0",      1'b1, 100, 0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 219,  4,  61);
    vecs[3] = mk("fs_len8_ff",    1'b0, 0,   8,  64'hFF00_0000_0000_0000, 1'b0, 471,  11, 145);
    vecs[4] = mk("len_clamp70",   1'b0, 0,   70, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2935, 67, 817);
    vecs[5] = mk("trcal_clamp12", 1'b1, 12,  0,  64'h0,                  1'b0, 132,  4,  61);
    vecs[6] = mk("trcal_clamp0",  1'b1, 0,   1,  64'h8000_0000_0000_0000, 1'b0, 176,  5,  73);
    vecs[7] = mk("crc_len16_0",   1'b0, 0,   16, 64'h0,                  1'b1, 519,  19, 241);

    reset = 1'b0; start = 1'b0; preamble = 1'b0; append_crc = 1'b0;
    trcal_cyc = '0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_modout", int'(modout), 1);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    reset = 1'b1;

    for (int k = 0; k < NV; k++) begin
      eb = vecs[k].exp_busy; er = vecs[k].exp_lowruns; el = vecs[k].exp_lowcyc;
      cv = '0;
`ifdef READER_CRC16_EN
      if (vecs[k].app) begin
        cv   = crc_model(vecs[k].data, int'(vecs[k].len));
        ones = $countones(cv);
        eb   = eb + 16 * 25 + ones * 19;
        er   = er + 16;
        el   = el + 16 * 12;
      end
`endif
      launch(vecs[k]);
      chk({vecs[k].name, "_lat_modout"}, int'(modout), 0);
      chk({vecs[k].name, "_lat_busy"},   int'(busy),   1);
      measure(0);
      chk({vecs[k].name, "_busy_cycles"}, busy_n, eb);
      chk({vecs[k].name, "_low_runs"},    lows.size(), er);
      chk({vecs[k].name, "_low_cycles"},  sum_lows(), el);
      chk({vecs[k].name, "_fin_done"},    int'(done), 1);
      chk({vecs[k].name, "_fin_modout"},  int'(modout), 1);
      if (k == 1 && highs.size() == 7) begin
        chk("p1010_hi_d0",    highs[0], 13);
        chk("p1010_hi_rtcal", highs[1], 57);
        chk("p1010_hi_trcal", highs[2], 126);
        chk("p1010_hi_b0",    highs[3], 32);
        chk("p1010_hi_b1",    highs[4], 13);
        chk("p1010_hi_b2",    highs[5], 32);
        chk("p1010_hi_b3",    highs[6], 13);
        foreach (lows[i]) chk("p1010_low_len", lows[i], (i == 0) ? 25 : 12);
      end else if (k == 1) begin
        chk("p1010_high_runs", highs.size(), 7);
      end
`ifdef READER_CRC16_EN
      if (vecs[k].app && highs.size() >= 16)
        for (int b = 0; b < 16; b++)
          chk("crc_bit_high", highs[highs.size() - 16 + b], cv[15-b] ? 32 : 13);
`endif
      @(negedge clk);
      chk({vecs[k].name, "_done_clear"}, int'(done), 0);
      chk({vecs[k].name, "_idle_busy"},  int'(busy), 0);
    end

    // start pulsed mid-frame is ignored and not queued
    launch(vecs[0]);
    measure(50);
    chk("midstart_busy_cycles", busy_n, 169);
    chk("midstart_done", int'(done), 1);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dcount += int'(busy);
    end
    chk("midstart_not_queued", dcount, 0);

    // start in FIN cycle launches the next frame back-to-back
    launch(vecs[0]);
    measure(0);
    chk("b2b_fin_done", int'(done), 1);
    preamble = 1'b0; cmd_len = 8'd2; cmd_data = '0; append_crc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_modout_low", int'(modout), 0);
    chk("b2b_busy",       int'(busy),   1);
    measure(0);
    chk("b2b_busy_cycles", busy_n, 169);
    @(negedge clk);

    // reset held 3 cycles mid-DATA aborts without a done pulse
    launch(vecs[3]);
    repeat (130) @(negedge clk);
    chk("abort_pre_busy", int'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_modout", int'(modout), 1);
    chk("abort_busy",   int'(busy),   0);
    dcount = int'(done);
    repeat (2) begin
      @(negedge clk);
      dcount += int'(done) + int'(busy);
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      dcount += int'(done) + int'(busy) + int'(!modout);
    end
    chk("abort_no_done_idle", dcount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
